// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Control FSM for a multicycle RV32I core. It runs one instruction at a time
// through the shared execute unit: fetch, decode, ALU/branch-compare, memory
// and writeback. It drives the execute unit's alu_ctrl code, the datapath mux
// selects and every write strobe.
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst          synchronous active-high reset; all outputs forced to 0
//   instr        instruction register contents (valid from DECODE onward)
//   br_en        branch-compare result from the execute unit
//   mem_ready    memory completes the current request this cycle
//   mem_req      memory request, held until mem_ready
//   mem_we       request is a store (qualified by mem_req)
//   mem_addr_sel memory address mux: 0 pc, 1 alu_out
//   ir_we        load the instruction register from mem_rdata
//   pc_we        update pc (exactly one pulse per retired instruction)
//   pc_sel       0 pc+4, 1 alu_out, 2 alu_out & ~1
//   alu_a_sel    0 rs1, 1 pc, 2 zero
//   alu_b_sel    0 rs2, 1 imm
//   alu_ctrl     execute-unit operation code
//   rf_we        register-file write
//   wb_sel       0 alu_out, 1 mem_rdata, 2 pc+4
//   halted       FSM is in HALT
//   trap_cause   0 none, 1 illegal instruction, 2 memory timeout (sticky)
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter bit          HALT_ON_EBREAK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        br_en,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic [1:0]  alu_a_sel,
  output logic [1:0]  alu_b_sel,
  output logic [3:0]  alu_ctrl,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        halted,
  output logic [1:0]  trap_cause
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_BR_TGT,
    S_MEM,
    S_WB,
    S_HALT,
    S_TRAP
  } state_t;

  // Major opcodes
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] INSN_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

  // Execute-unit codes for arithmetic/logic operations
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  // Execute-unit codes for branch compares (same bus, different meaning)
  localparam logic [3:0] BR_BEQ  = 4'd0;
  localparam logic [3:0] BR_BNE  = 4'd1;
  localparam logic [3:0] BR_BLT  = 4'd2;
  localparam logic [3:0] BR_BGE  = 4'd3;
  localparam logic [3:0] BR_BLTU = 4'd4;
  localparam logic [3:0] BR_BGEU = 4'd5;

  localparam logic [1:0] A_RS1  = 2'd0;
  localparam logic [1:0] A_PC   = 2'd1;
  localparam logic [1:0] A_ZERO = 2'd2;
  localparam logic [1:0] B_RS2  = 2'd0;
  localparam logic [1:0] B_IMM  = 2'd1;

  localparam logic [1:0] PC_PLUS4   = 2'd0;
  localparam logic [1:0] PC_ALU     = 2'd1;
  localparam logic [1:0] PC_ALU_JR  = 2'd2;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_LINK = 2'd2;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  // The wait timer only has to reach TIMEOUT_CYCLES-1: the cycle on which it
  // holds that value is the last one memory is allowed to answer in.
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam int TIMER_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LIMIT =
    TIMER_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t               state_reg, state_next;
  logic [TIMER_W-1:0]   timer_reg, timer_next;
  logic                 taken_reg, taken_next;
  logic [1:0]           trap_cause_reg, trap_cause_next;

  // ---------------------------------------------------------------------------
  // Instruction decode
  // ---------------------------------------------------------------------------
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  logic is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store;
  logic is_op_imm, is_op, is_fence, is_sys_halt;

  assign is_lui    = (opcode == OPC_LUI);
  assign is_auipc  = (opcode == OPC_AUIPC);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_op_imm = (opcode == OPC_OP_IMM);
  assign is_op     = (opcode == OPC_OP);
  assign is_fence  = (opcode == OPC_FENCE);
  // Only the exact ECALL/EBREAK encodings halt; every other SYSTEM encoding
  // decodes as illegal.
  assign is_sys_halt = HALT_ON_EBREAK && ((instr == INSN_ECALL) || (instr == INSN_EBREAK));

  logic illegal;

  always_comb begin
    illegal = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_FENCE: illegal = 1'b0;
      OPC_BRANCH: illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
      OPC_LOAD:   illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      OPC_STORE:  illegal = (funct3 > 3'b010);
      OPC_OP: begin
        if (funct7 == 7'h00)
          illegal = 1'b0;
        else if (funct7 == 7'h20)
          illegal = !((funct3 == 3'b000) || (funct3 == 3'b101));
        else
          illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        // Only the shift-immediates constrain the upper bits; for the rest
        // they are part of the immediate.
        if (funct3 == 3'b001)
          illegal = (funct7 != 7'h00);
        else if (funct3 == 3'b101)
          illegal = (funct7 != 7'h00) && (funct7 != 7'h20);
        else
          illegal = 1'b0;
      end
      OPC_SYSTEM: illegal = !is_sys_halt;
      default:    illegal = 1'b1;
    endcase
  end

  // Operation and operand selects used in EXEC
  logic [3:0] exec_alu_op;
  logic [1:0] exec_a_sel;
  logic [1:0] exec_b_sel;

  always_comb begin
    exec_alu_op = ALU_ADD;
    if (is_op || is_op_imm) begin
      case (funct3)
        // funct7[5] selects SUB only for register-register; for OP-IMM that
        // bit belongs to the immediate.
        3'b000:  exec_alu_op = (is_op && funct7[5]) ? ALU_SUB : ALU_ADD;
        3'b001:  exec_alu_op = ALU_SLL;
        3'b010:  exec_alu_op = ALU_SLT;
        3'b011:  exec_alu_op = ALU_SLTU;
        3'b100:  exec_alu_op = ALU_XOR;
        3'b101:  exec_alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
        3'b110:  exec_alu_op = ALU_OR;
        default: exec_alu_op = ALU_AND;
      endcase
    end else if (is_branch) begin
      case (funct3)
        3'b000:  exec_alu_op = BR_BEQ;
        3'b001:  exec_alu_op = BR_BNE;
        3'b100:  exec_alu_op = BR_BLT;
        3'b101:  exec_alu_op = BR_BGE;
        3'b110:  exec_alu_op = BR_BLTU;
        default: exec_alu_op = BR_BGEU;
      endcase
    end
  end

  always_comb begin
    exec_a_sel = A_RS1;
    exec_b_sel = B_IMM;
    if (is_op || is_branch)
      exec_b_sel = B_RS2;
    if (is_lui)
      exec_a_sel = A_ZERO;
    else if (is_auipc || is_jal)
      exec_a_sel = A_PC;
  end

  // ---------------------------------------------------------------------------
  // Memory wait timer helpers
  // ---------------------------------------------------------------------------
  logic               timer_hit;
  logic [TIMER_W-1:0] timer_inc;

  assign timer_hit = TIMEOUT_EN && (timer_reg == TIMER_LIMIT);
  assign timer_inc = TIMEOUT_EN ? (timer_reg + TIMER_W'(1)) : '0;

  // ---------------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    timer_next      = '0;
    taken_next      = taken_reg;
    trap_cause_next = trap_cause_reg;

    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = PC_PLUS4;
    alu_a_sel    = A_RS1;
    alu_b_sel    = B_RS2;
    alu_ctrl     = ALU_ADD;
    rf_we        = 1'b0;
    wb_sel       = WB_ALU;
    halted       = 1'b0;
    trap_cause   = CAUSE_NONE;

    // Reset forces every output low in the same cycle, so an in-flight
    // memory request is dropped immediately.
    if (!rst) begin
      halted     = (state_reg == S_HALT);
      trap_cause = trap_cause_reg;

      case (state_reg)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_we      = 1'b1;
            state_next = S_DECODE;
          end else if (timer_hit) begin
            state_next      = S_TRAP;
            trap_cause_next = CAUSE_TIMEOUT;
          end else begin
            timer_next = timer_inc;
          end
        end

        S_DECODE: begin
          if (illegal) begin
            state_next      = S_TRAP;
            trap_cause_next = CAUSE_ILLEGAL;
          end else if (is_sys_halt) begin
            state_next = S_HALT;
          end else if (is_fence) begin
            state_next = S_WB;
          end else begin
            state_next = S_EXEC;
          end
        end

        S_EXEC: begin
          alu_ctrl  = exec_alu_op;
          alu_a_sel = exec_a_sel;
          alu_b_sel = exec_b_sel;
          if (is_branch) begin
            // The compare result is only valid now; keep it for WB.
            taken_next = br_en;
            state_next = S_BR_TGT;
          end else if (is_load || is_store) begin
            state_next = S_MEM;
          end else begin
            state_next = S_WB;
          end
        end

        S_BR_TGT: begin
          alu_ctrl   = ALU_ADD;
          alu_a_sel  = A_PC;
          alu_b_sel  = B_IMM;
          state_next = S_WB;
        end

        S_MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = is_store;
          // Keep the address computation selected so alu_out stays stable
          // however long memory stalls.
          alu_ctrl     = ALU_ADD;
          alu_a_sel    = A_RS1;
          alu_b_sel    = B_IMM;
          if (mem_ready) begin
            if (is_store) begin
              // Stores have nothing to write back and retire here.
              pc_we      = 1'b1;
              pc_sel     = PC_PLUS4;
              state_next = S_FETCH;
            end else begin
              state_next = S_WB;
            end
          end else if (timer_hit) begin
            state_next      = S_TRAP;
            trap_cause_next = CAUSE_TIMEOUT;
          end else begin
            timer_next = timer_inc;
          end
        end

        S_WB: begin
          pc_we      = 1'b1;
          state_next = S_FETCH;
          if (is_op || is_op_imm || is_lui || is_auipc) begin
            rf_we  = 1'b1;
            wb_sel = WB_ALU;
          end else if (is_load) begin
            rf_we  = 1'b1;
            wb_sel = WB_MEM;
          end else if (is_jal || is_jalr) begin
            rf_we  = 1'b1;
            wb_sel = WB_LINK;
          end
          if (is_jal || (is_branch && taken_reg))
            pc_sel = PC_ALU;
          else if (is_jalr)
            pc_sel = PC_ALU_JR;
          else
            pc_sel = PC_PLUS4;
        end

        S_HALT, S_TRAP: begin
          state_next = state_reg;
        end

        default: begin
          state_next = S_FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_FETCH;
      timer_reg      <= '0;
      taken_reg      <= 1'b0;
      trap_cause_reg <= CAUSE_NONE;
    end else begin
      state_reg      <= state_next;
      timer_reg      <= timer_next;
      taken_reg      <= taken_next;
      trap_cause_reg <= trap_cause_next;
    end
  end

endmodule
